// File: rtl/prog_halt_pkg.sv
// Shared types and default constants for the program-halt monitor.
// Optional statistics counters are enabled by defining PHM_STATS_EN.
package prog_halt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } phm_state_e;

  localparam int          DEF_DATA_W    = 32;
  localparam logic [31:0] DEF_HALT_WORD = 32'h0000_0000;
  localparam int          DEF_HALT_RUN  = 4;
  localparam int          DEF_CNT_W     = 32;

  // Bits needed to hold a terminator run length of 0..halt_run.
  function automatic int run_cnt_width(input int halt_run);
    return $clog2(halt_run + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping; clr beats inc.
// Instantiated by prog_halt_monitor only when PHM_STATS_EN is defined.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prog_halt_monitor.sv
// Detects end-of-program as HALT_RUN consecutive HALT_WORD fetches in IF/ID.
// Define PHM_STATS_EN to build the cycle/instruction statistics counters.
module prog_halt_monitor
  import prog_halt_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(DEF_HALT_WORD),
  parameter int                HALT_RUN  = DEF_HALT_RUN,
  parameter int                CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic [DATA_W-1:0] instruction_ifid,
  input  logic              clear_program_finished,
  output logic              program_end,
  output logic              running,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int RUN_W = run_cnt_width(HALT_RUN);

  phm_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             program_end_q, program_end_d;
  logic             is_halt;
  logic             do_clear;

  assign is_halt  = (instruction_ifid == HALT_WORD);
  assign do_clear = clk_enable && clear_program_finished;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      run_cnt_q     <= '0;
      program_end_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      program_end_q <= program_end_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    program_end_d = program_end_q;
    if (do_clear) begin
      state_d       = IDLE;
      run_cnt_d     = '0;
      program_end_d = 1'b0;
    end else if (clk_enable) begin
      unique case (state_q)
        IDLE: begin
          if (!is_halt) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (is_halt) begin
            if (HALT_RUN == 1) begin
              state_d       = DONE;
              run_cnt_d     = RUN_W'(1);
              program_end_d = 1'b1;
            end else begin
              state_d   = DRAIN;
              run_cnt_d = RUN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!is_halt) begin
            state_d   = RUN;
            run_cnt_d = '0;
          end else begin
            run_cnt_d = run_cnt_q + RUN_W'(1);
            if (run_cnt_q == RUN_W'(HALT_RUN - 1)) begin
              state_d       = DONE;
              program_end_d = 1'b1;
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    running     = (state_q == RUN) || (state_q == DRAIN);
    program_end = program_end_q;
  end

`ifdef PHM_STATS_EN
  logic cyc_inc;
  logic instr_inc;

  // The edge that leaves IDLE is the first counted cycle of the program.
  assign cyc_inc   = clk_enable && !clear_program_finished &&
                     (running || ((state_q == IDLE) && !is_halt));
  assign instr_inc = clk_enable && !clear_program_finished &&
                     !is_halt && (state_q != DONE);

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clear),
    .inc   (cyc_inc),
    .count (cycle_count)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (do_clear),
    .inc   (instr_inc),
    .count (instr_count)
  );
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: doc/prog_halt_monitor.md
PROG_HALT_MONITOR -- requirements
Module: prog_halt_monitor

Interface
REQ-001 Parameter DATA_W, default 32: width of the fetched instruction word.
REQ-002 Parameter HALT_WORD, default 0 (DATA_W bits): terminator pattern compared against each fetched word.
REQ-003 Parameter HALT_RUN, default 4, legal range 1..15: consecutive terminator words that end the program.
REQ-004 Parameter CNT_W, default 32: width of the statistics counters.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 clk_enable  in  1  sample qualifier; when low, all state holds.
REQ-008 instruction_ifid  in  DATA_W  word currently in the IF/ID register.
REQ-009 clear_program_finished  in  1  synchronous clear of the finished flag and all state.
REQ-010 program_end  out  1  registered, sticky program-finished flag.
REQ-011 running  out  1  high while the FSM is in RUN or DRAIN.
REQ-012 cycle_count  out  CNT_W  enabled cycles spent in RUN/DRAIN.
REQ-013 instr_count  out  CNT_W  non-terminator words sampled since start.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE; all transitions only on edges with clk_enable=1.
REQ-015 IDLE: terminator words are ignored; the first non-terminator word moves the FSM to RUN, and instr_count becomes 1.
REQ-016 RUN: a terminator word moves the FSM to DRAIN with run_cnt=1; a non-terminator word stays in RUN.
REQ-017 DRAIN: a terminator word increments run_cnt; a non-terminator word returns the FSM to RUN with run_cnt=0.
REQ-018 When HALT_RUN consecutive terminator words have been sampled, the FSM enters DONE and program_end rises on that same edge (1-edge latency, visible the following cycle).
REQ-019 If HALT_RUN=1, the first terminator in RUN goes directly to DONE.
REQ-020 DONE is absorbing: program_end=1, running=0, and counters frozen until reset or clear.
REQ-021 cycle_count increments on every enabled edge on which the FSM is in RUN or DRAIN, including the edge that enters DONE.
REQ-022 instr_count increments on every enabled non-terminator sample outside DONE.
REQ-023 Both counters saturate at 2^CNT_W-1 and never wrap.
REQ-024 run_cnt is ceil(log2(HALT_RUN+1)) bits wide and resets to 0 on any non-terminator word.
REQ-025 Comparison is a full DATA_W-bit equality against HALT_WORD; there is no masking.
REQ-026 clear_program_finished=1 with clk_enable=1 forces IDLE and zeroes run_cnt, program_end and both counters; it overrides any simultaneous terminator or start event.
REQ-027 clear_program_finished while clk_enable=0 has no effect.
REQ-028 running is combinational from state; program_end is a flop output.

Reset
REQ-029 reset=0 on a rising edge forces IDLE, run_cnt=0, program_end=0, running=0, cycle_count=0 and instr_count=0, independent of clk_enable.
REQ-030 Reset asserted mid-DRAIN or in DONE discards all progress; the first enabled edge after release evaluates as IDLE.
REQ-031 Reset has priority over clear_program_finished.

Configuration
REQ-032 Macro PHM_STATS_EN defined: cycle_count and instr_count are implemented as specified.
REQ-033 PHM_STATS_EN undefined: no counter flops are built; cycle_count and instr_count are driven constant 0, and all FSM behaviour is unchanged.

Structure
REQ-034 Package prog_halt_pkg holds the state enum (IDLE/RUN/DRAIN/DONE) and the default constants for DATA_W, HALT_WORD, HALT_RUN and CNT_W.
REQ-035 Sub-module sat_counter (parameter width; inputs clr and inc; output count) is instantiated twice, for cycle_count and instr_count, and only under PHM_STATS_EN.

Verification (defaults, clk_enable=1 unless stated)
REQ-036 Words 0,0,5,6,0,0,0,0 after reset -> program_end rises after the 8th word; instr_count=2; cycle_count=6.
REQ-037 Words 7,0,0,0,9,0,0,0,0 -> no end after the first three zeros; program_end=1 after the final zero; instr_count=2.
REQ-038 Sequence 7,0,0,0,0 with clk_enable=0 on the 3rd zero -> that zero is ignored; end occurs one accepted zero later and cycle_count excludes the stalled cycle.
REQ-039 In DONE, clear_program_finished=1 together with word 0 -> program_end=0, state IDLE, counters 0; then 3,0,0,0,0 -> program_end=1 again.
REQ-040 CNT_W=3 with 10 non-terminator words -> instr_count holds at 7 with no wrap.
REQ-041 Build without PHM_STATS_EN, rerun REQ-036 -> identical program_end timing; counters read 0.
